// File: rtl/iiitb_lifo_pkg.sv
// -----------------------------------------------------------------------------
// iiitb_lifo_pkg
// Shared definitions for the LIFO stack and its upstream command sequencer:
// the default stack geometry, the controller state encoding and the RW
// command encoding used on the stack's single-port interface.
// -----------------------------------------------------------------------------
package iiitb_lifo_pkg;

  // Default stack geometry; must agree with the LIFO instance being driven.
  localparam int DEPTH_DEF = 4;
  localparam int WIDTH_DEF = 4;

  // RW encoding on the stack port.
  localparam logic RW_PUSH = 1'b0;
  localparam logic RW_POP  = 1'b1;

  // INIT holds the stack in reset for one cycle; IDLE accepts requests.
  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

endpackage

// File: rtl/iiitb_lifo_ctrl.sv
// -----------------------------------------------------------------------------
// iiitb_lifo_ctrl
// Command sequencer sitting in front of the 4-deep LIFO stack. Converts the
// independent push (valid/ready) and pop (req/ready) streams into the stack's
// EN/RW/Rst command protocol, keeps a local occupancy count, and captures
// popped words from the stack with a one-cycle pop_valid strobe.
//
// Ports:
//   Clk, Rst         clock, synchronous active-high reset
//   clear            soft clear; flushes in-flight pops and re-inits the stack
//   push_valid/data  push request and word; push_ready accepts it
//   pop_req          pop request; pop_ready accepts it
//   pop_valid/data   popped word, strobed for one cycle, data held afterwards
//   count            local occupancy 0..DEPTH
//   lifo_EN/RW/Rst   command outputs to the stack
//   lifo_dataIn      word to the stack
//   lifo_dataOut     word from the stack
// -----------------------------------------------------------------------------
module iiitb_lifo_ctrl
  import iiitb_lifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             clear,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pop_req,
  output logic             pop_ready,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             lifo_EN,
  output logic             lifo_RW,
  output logic             lifo_Rst,
  output logic [WIDTH-1:0] lifo_dataIn,
  input  logic [WIDTH-1:0] lifo_dataOut
);

  state_t          state;
  logic            cmd_en_q;
  logic [1:0]      pending;
  logic [CW-1:0]   count_q;
  logic            pop_acc;
  logic            push_acc;
  logic            idle_clear;

  // Pop wins over push when both are requested, so push_ready looks at the
  // pop handshake; clear blocks both so nothing is accepted in a clear cycle.
  assign pop_ready  = !Rst && (state == IDLE) && (count_q != '0) && !clear;
  assign push_ready = !Rst && (state == IDLE) && (count_q != CW'(DEPTH)) &&
                      !clear && !(pop_req && pop_ready);
  assign pop_acc    = pop_req && pop_ready;
  assign push_acc   = push_valid && push_ready;
  assign idle_clear = (state == IDLE) && clear;

  // The stack is held in reset while Rst is high and for the INIT cycle;
  // EN must accompany Rst for the stack to act on it.
  assign lifo_Rst = Rst | (state == INIT);
  assign lifo_EN  = cmd_en_q | lifo_Rst;
  assign count    = count_q;

  // Main sequencer. A pop accepted at edge E is executed by the stack at E+1,
  // so its word is on lifo_dataOut by E+2; pending[1] marks that edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= INIT;
      count_q     <= '0;
      cmd_en_q    <= 1'b0;
      lifo_RW     <= RW_PUSH;
      lifo_dataIn <= '0;
      pop_valid   <= 1'b0;
      pop_data    <= '0;
      pending     <= '0;
    end else begin
      cmd_en_q <= 1'b0;
      if (idle_clear) begin
        state     <= INIT;
        count_q   <= '0;
        pending   <= '0;
        pop_valid <= 1'b0;
      end else begin
        pending   <= {pending[0], pop_acc};
        pop_valid <= pending[1];
        if (pending[1]) begin
          pop_data <= lifo_dataOut;
        end
        if (state == INIT) begin
          state <= IDLE;
        end else if (pop_acc) begin
          cmd_en_q <= 1'b1;
          lifo_RW  <= RW_POP;
          count_q  <= count_q - 1'b1;
        end else if (push_acc) begin
          cmd_en_q    <= 1'b1;
          lifo_RW     <= RW_PUSH;
          lifo_dataIn <= push_data;
          count_q     <= count_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iiitb_lifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_iiitb_lifo_ctrl
// Bench for the LIFO command sequencer. A behavioural 4-deep stack is attached
// to the controller's command port; a reference model predicts readiness,
// occupancy and popped words, and popped words are scoreboarded with the
// cycle on which pop_valid must appear.
// -----------------------------------------------------------------------------
module tb_iiitb_lifo_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       clear = 1'b0;
  logic       push_valid = 1'b0;
  logic [3:0] push_data = 4'h0;
  logic       push_ready;
  logic       pop_req = 1'b0;
  logic       pop_ready;
  logic       pop_valid;
  logic [3:0] pop_data;
  logic [2:0] count;
  logic       lifo_EN;
  logic       lifo_RW;
  logic       lifo_Rst;
  logic [3:0] lifo_dataIn;
  logic [3:0] lifo_dataOut;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] data;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] m_stk[$];
  int         m_count = 0;
  logic       m_init = 1'b1;

  iiitb_lifo_ctrl dut (
    .Clk(Clk), .Rst(Rst), .clear(clear),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_req(pop_req), .pop_ready(pop_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .count(count),
    .lifo_EN(lifo_EN), .lifo_RW(lifo_RW), .lifo_Rst(lifo_Rst),
    .lifo_dataIn(lifo_dataIn), .lifo_dataOut(lifo_dataOut)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural stack on the far side of the command port.
  logic [3:0] stk_mem [4];
  int         stk_sp = 0;
  logic [3:0] stk_out = 4'h0;
  assign lifo_dataOut = stk_out;

  always @(posedge Clk) begin
    if (lifo_EN) begin
      if (lifo_Rst) begin
        stk_sp  <= 0;
        stk_out <= 4'h0;
      end else if (lifo_RW == 1'b0) begin
        if (stk_sp < 4) begin
          stk_mem[stk_sp] <= lifo_dataIn;
          stk_sp          <= stk_sp + 1;
        end
      end else if (stk_sp > 0) begin
        stk_out <= stk_mem[stk_sp-1];
        stk_sp  <= stk_sp - 1;
      end
    end
  end

  // Scoreboard monitor: every pop_valid must match the oldest expected word
  // on exactly its due cycle.
  always @(negedge Clk) begin
    if (pop_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL pop_valid_unexpected cycle=%0d data=%h required=no strobe", cyc, pop_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (pop_data !== e.data || cyc != e.due) begin
          failures++;
          $display("[TB] FAIL pop_data data=%h cycle=%0d required data=%h cycle=%0d",
                   pop_data, cyc, e.data, e.due);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL pop_valid_missing cycle=%0d required data=%h at cycle=%0d", cyc, e.data, e.due);
    end
  end

  function automatic logic m_pop_rdy();
    return !Rst && !m_init && (m_count != 0) && !clear;
  endfunction

  function automatic logic m_push_rdy();
    return !Rst && !m_init && (m_count != 4) && !clear && !(pop_req && m_pop_rdy());
  endfunction

  task automatic set_inputs(input logic pv, input logic [3:0] pd, input logic pr, input logic clr);
    push_valid = pv;
    push_data  = pd;
    pop_req    = pr;
    clear      = clr;
    #1;
  endtask

  // Advance one clock and step the reference model with the accepted operation.
  task automatic tick();
    logic pa, pu;
    int   now;
    exp_t e;
    pa  = pop_req && m_pop_rdy();
    pu  = push_valid && m_push_rdy();
    now = cyc;
    @(posedge Clk);
    if (Rst || (!m_init && clear)) begin
      m_init  = 1'b1;
      m_count = 0;
      m_stk.delete();
      exp_q.delete();
    end else if (m_init) begin
      m_init = 1'b0;
    end else if (pa) begin
      e.data = m_stk[$];
      e.due  = now + 3;
      exp_q.push_back(e);
      void'(m_stk.pop_back());
      m_count--;
    end else if (pu) begin
      m_stk.push_back(push_data);
      m_count++;
    end
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_inputs(1'b0, 4'h0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    @(negedge Clk);
    #1;
    checks++;
    if ({lifo_EN, lifo_Rst, push_ready, pop_ready, pop_valid} !== 5'b11000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl EN/Rst/pushR/popR/valid=%b required=11000",
               {lifo_EN, lifo_Rst, push_ready, pop_ready, pop_valid});
    end
    checks++;
    if ({count, lifo_RW, lifo_dataIn, pop_data} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_regs count=%0d RW=%b dataIn=%h pop_data=%h required all zero",
               count, lifo_RW, lifo_dataIn, pop_data);
    end
    tick();
    Rst = 1'b0;
    #1;
    checks++;
    if ({lifo_EN, lifo_Rst, push_ready, pop_ready} !== 4'b1100) begin
      failures++;
      $display("[TB] FAIL init_cycle EN/Rst/pushR/popR=%b required=1100",
               {lifo_EN, lifo_Rst, push_ready, pop_ready});
    end
    tick();
    set_inputs(1'b0, 4'h0, 1'b0, 1'b0);
    checks++;
    if ({push_ready, pop_ready, lifo_Rst, lifo_EN} !== 4'b1000 || count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset pushR/popR/Rst/EN=%b count=%0d required=1000 count=0",
               {push_ready, pop_ready, lifo_Rst, lifo_EN}, count);
    end
  endtask

  task automatic test_fill();
    logic [3:0] words [4] = '{4'h3, 4'h7, 4'hA, 4'h5};
    for (int i = 0; i < 4; i++) begin
      set_inputs(1'b1, words[i], 1'b0, 1'b0);
      checks++;
      if (push_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL fill_push_ready push %0d got=%b required=1", i, push_ready);
      end
      tick();
    end
    set_inputs(1'b1, 4'hB, 1'b0, 1'b0);
    checks++;
    if (count !== 3'd4 || push_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_state count=%0d pushR=%b required count=4 pushR=0", count, push_ready);
    end
    tick();
    checks++;
    if (lifo_EN !== 1'b0 || count !== 3'd4) begin
      failures++;
      $display("[TB] FAIL full_stall EN=%b count=%0d required EN=0 count=4", lifo_EN, count);
    end
  endtask

  task automatic test_pop_all();
    for (int i = 0; i < 4; i++) begin
      set_inputs(1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (pop_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL pop_all_ready pop %0d got=%b required=1", i, pop_ready);
      end
      tick();
      if (i == 0) begin
        checks++;
        if (lifo_EN !== 1'b1 || lifo_RW !== 1'b1) begin
          failures++;
          $display("[TB] FAIL pop_cmd EN=%b RW=%b required EN=1 RW=1", lifo_EN, lifo_RW);
        end
      end
    end
    set_inputs(1'b0, 4'h0, 1'b1, 1'b0);
    checks++;
    if (count !== 3'd0 || pop_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL empty_state count=%0d popR=%b required count=0 popR=0", count, pop_ready);
    end
    tick();
    idle(3);
  endtask

  task automatic test_back_to_back();
    set_inputs(1'b1, 4'h1, 1'b0, 1'b0);
    tick();
    set_inputs(1'b1, 4'h2, 1'b0, 1'b0);
    tick();
    set_inputs(1'b1, 4'hC, 1'b1, 1'b0);
    checks++;
    if (pop_ready !== 1'b1 || push_ready !== 1'b0 || count !== 3'd2) begin
      failures++;
      $display("[TB] FAIL simultaneous popR=%b pushR=%b count=%0d required popR=1 pushR=0 count=2",
               pop_ready, push_ready, count);
    end
    tick();
    set_inputs(1'b1, 4'hC, 1'b0, 1'b0);
    checks++;
    if (push_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stalled_push_ready got=%b required=1", push_ready);
    end
    tick();
    set_inputs(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    idle(3);
    checks++;
    if (pop_data !== 4'hC || count !== 3'd1) begin
      failures++;
      $display("[TB] FAIL simultaneous_result pop_data=%h count=%0d required C count=1", pop_data, count);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) begin
      set_inputs(1'b1, 4'(4'h4 + i), 1'b0, 1'b0);
      tick();
    end
    set_inputs(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    set_inputs(1'b1, 4'hE, 1'b1, 1'b1);
    checks++;
    if (count !== 3'd3 || pop_ready !== 1'b0 || push_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_gating count=%0d popR=%b pushR=%b required count=3 popR=0 pushR=0",
               count, pop_ready, push_ready);
    end
    tick();
    set_inputs(1'b0, 4'h0, 1'b1, 1'b0);
    checks++;
    if (count !== 3'd0 || lifo_Rst !== 1'b1 || lifo_EN !== 1'b1 || pop_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_init count=%0d Rst=%b EN=%b popR=%b required 0 1 1 0",
               count, lifo_Rst, lifo_EN, pop_ready);
    end
    tick();
    set_inputs(1'b0, 4'h0, 1'b1, 1'b0);
    checks++;
    if (pop_ready !== 1'b0 || lifo_Rst !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_refuse popR=%b Rst=%b required popR=0 Rst=0", pop_ready, lifo_Rst);
    end
    tick();
    idle(3);
  endtask

  task automatic test_rst_mid();
    set_inputs(1'b1, 4'h9, 1'b0, 1'b0);
    tick();
    set_inputs(1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    Rst = 1'b1;
    set_inputs(1'b0, 4'h0, 1'b0, 1'b0);
    checks++;
    if (lifo_Rst !== 1'b1 || lifo_EN !== 1'b1 || pop_ready !== 1'b0 || push_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_mid_cmd Rst=%b EN=%b popR=%b pushR=%b required 1 1 0 0",
               lifo_Rst, lifo_EN, pop_ready, push_ready);
    end
    tick();
    Rst = 1'b0;
    idle(4);
    checks++;
    if (count !== 3'd0 || pop_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_mid_after count=%0d pop_valid=%b required count=0 valid=0", count, pop_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_inputs(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0));
      checks++;
      if (push_ready !== m_push_rdy() || pop_ready !== m_pop_rdy() || count !== 3'(m_count)) begin
        failures++;
        $display("[TB] FAIL random_step %0d pushR=%b popR=%b count=%0d required %b %b %0d",
                 i, push_ready, pop_ready, count, m_push_rdy(), m_pop_rdy(), m_count);
      end
      tick();
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pop_all();
    test_back_to_back();
    test_clear();
    test_rst_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain outstanding=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
